// File: rtl/usb_defs_pkg.sv
// Shared USB definitions for the EP0 control sequencer: PIDs, standard request codes, FSM states.
package usb_defs_pkg;

  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
  localparam logic [7:0] REQ_GET_CONFIGURATION = 8'h08;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;

  localparam logic [7:0] RT_STD_DEV_OUT = 8'h00;
  localparam logic [7:0] RT_STD_DEV_IN  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP_RX   = 3'd1,
    ST_DATA_IN    = 3'd2,
    ST_STATUS_OUT = 3'd3,
    ST_STATUS_IN  = 3'd4,
    ST_STALLED    = 3'd5
  } ep0_state_t;

endpackage

// File: rtl/usb_setup_capture.sv
// Captures the 8-byte SETUP payload by index, checks length/CRC at packet end and
// exposes the request fields with the final byte merged in on the same cycle.
module usb_setup_capture
  import usb_defs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        active_i,
  input  logic        rx_data_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_pkt_end_i,
  input  logic        rx_crc_err_i,
  output logic        setup_ok_o,
  output logic        setup_bad_o,
  output logic [7:0]  bm_req_type_o,
  output logic [7:0]  b_request_o,
  output logic [15:0] w_value_o,
  output logic [15:0] w_length_o
);

  logic [7:0] bytes_q [8];
  logic [7:0] bytes_c [8];
  logic [3:0] cnt_q, cnt_d;
  logic       take_byte;
  logic       pkt_done;
  logic       unused_windex;

  // Bytes past the eighth are neither stored nor counted.
  assign take_byte = active_i && rx_data_valid_i && (cnt_q < 4'd8);

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 4'd0;
    end else if (take_byte) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (take_byte && (cnt_q == 4'(i))) begin
        bytes_q[i] <= rx_data_i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bytes_c[i] = bytes_q[i];
      if (take_byte && (cnt_q == 4'(i))) begin
        bytes_c[i] = rx_data_i;
      end
    end
  end

  assign pkt_done    = active_i && rx_pkt_end_i && !start_i;
  assign setup_ok_o  = pkt_done && (cnt_d == 4'd8) && !rx_crc_err_i;
  assign setup_bad_o = pkt_done && !setup_ok_o;

  assign bm_req_type_o = bytes_c[0];
  assign b_request_o   = bytes_c[1];
  assign w_value_o     = {bytes_c[3], bytes_c[2]};
  assign w_length_o    = {bytes_c[7], bytes_c[6]};
  assign unused_windex = ^{bytes_c[4], bytes_c[5]};

endmodule

// File: rtl/usb_ep0_ctrl_seq.sv
// EP0 control-transfer sequencer for SET_ADDRESS, SET/GET_CONFIGURATION.
// Optional idle-token abort enabled by defining USB_EP0_TIMEOUT_EN.
module usb_ep0_ctrl_seq
  import usb_defs_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tok_valid,
  input  logic [3:0]  tok_pid,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_pkt_end,
  input  logic        rx_crc_err,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [3:0]  tx_pid,
  output logic [15:0] tx_len,
  output logic [7:0]  tx_data,
  output logic [6:0]  dev_addr,
  output logic [7:0]  config_val,
  output logic [2:0]  ctrl_state
);

  ep0_state_t  state_q, state_d;
  logic        tx_valid_q, tx_valid_d;
  logic [3:0]  tx_pid_q, tx_pid_d;
  logic [15:0] tx_len_q, tx_len_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [6:0]  dev_addr_q, dev_addr_d;
  logic [7:0]  config_q, config_d;
  logic [6:0]  pend_addr_q, pend_addr_d;
  logic [7:0]  pend_cfg_q, pend_cfg_d;
  logic        pend_is_addr_q, pend_is_addr_d;
  logic        out_seen_q, out_seen_d;
  logic        out_data_q, out_data_d;

  logic        is_setup, tok_ok, timeout;
  logic        resp_en;
  logic [3:0]  resp_pid;
  logic [15:0] resp_len;
  logic [7:0]  resp_data;

  logic        setup_ok, setup_bad;
  logic [7:0]  bm_req_type, b_request;
  logic [15:0] w_value, w_length;

  assign is_setup = tok_valid && (tok_pid == PID_SETUP);
  // Non-SETUP tokens are dropped while a response is still waiting for the transmitter.
  assign tok_ok   = tok_valid && !(tx_valid_q && !tx_ready);

  usb_setup_capture u_capture (
    .clk             (clk),
    .rst             (rst),
    .start_i         (is_setup),
    .active_i        (state_q == ST_SETUP_RX),
    .rx_data_valid_i (rx_data_valid),
    .rx_data_i       (rx_data),
    .rx_pkt_end_i    (rx_pkt_end),
    .rx_crc_err_i    (rx_crc_err),
    .setup_ok_o      (setup_ok),
    .setup_bad_o     (setup_bad),
    .bm_req_type_o   (bm_req_type),
    .b_request_o     (b_request),
    .w_value_o       (w_value),
    .w_length_o      (w_length)
  );

`ifdef USB_EP0_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE) || tok_valid) begin
      to_cnt_q <= 16'd0;
    end else if (to_cnt_q != 16'hFFFF) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign timeout = (state_q != ST_IDLE) && (to_cnt_q >= TO_LIM);
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    tx_valid_d     = tx_valid_q;
    tx_pid_d       = tx_pid_q;
    tx_len_d       = tx_len_q;
    tx_data_d      = tx_data_q;
    dev_addr_d     = dev_addr_q;
    config_d       = config_q;
    pend_addr_d    = pend_addr_q;
    pend_cfg_d     = pend_cfg_q;
    pend_is_addr_d = pend_is_addr_q;
    out_seen_d     = out_seen_q;
    out_data_d     = out_data_q;
    resp_en        = 1'b0;
    resp_pid       = PID_ACK;
    resp_len       = 16'd0;
    resp_data      = 8'd0;

    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_SETUP_RX: begin
        if (setup_ok) begin
          resp_en = 1'b1;
          if ((bm_req_type == RT_STD_DEV_OUT) && (b_request == REQ_SET_ADDRESS) &&
              (w_value <= 16'd127)) begin
            pend_addr_d    = w_value[6:0];
            pend_is_addr_d = 1'b1;
            state_d        = ST_STATUS_IN;
          end else if ((bm_req_type == RT_STD_DEV_OUT) &&
                       (b_request == REQ_SET_CONFIGURATION) && (w_value <= 16'd1)) begin
            pend_cfg_d     = w_value[7:0];
            pend_is_addr_d = 1'b0;
            state_d        = ST_STATUS_IN;
          end else if ((bm_req_type == RT_STD_DEV_IN) &&
                       (b_request == REQ_GET_CONFIGURATION) && (w_length >= 16'd1)) begin
            state_d = ST_DATA_IN;
          end else begin
            state_d = ST_STALLED;
          end
        end else if (setup_bad) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_IN: begin
        if (tok_ok && (tok_pid == PID_IN)) begin
          resp_en   = 1'b1;
          resp_pid  = PID_DATA1;
          resp_len  = 16'd1;
          resp_data = config_q;
        end else if (tok_ok && (tok_pid == PID_ACK)) begin
          out_seen_d = 1'b0;
          state_d    = ST_STATUS_OUT;
        end
      end
      ST_STATUS_OUT: begin
        if (tok_ok && (tok_pid == PID_OUT)) begin
          out_seen_d = 1'b1;
          out_data_d = 1'b0;
        end
        if (out_seen_q && rx_data_valid) begin
          out_data_d = 1'b1;
        end
        // Only a clean zero-length packet completes the status stage.
        if (out_seen_q && rx_pkt_end) begin
          if (!rx_crc_err && !rx_data_valid && !out_data_q) begin
            resp_en = 1'b1;
            state_d = ST_IDLE;
          end else begin
            out_seen_d = 1'b0;
          end
        end
      end
      ST_STATUS_IN: begin
        if (tok_ok && (tok_pid == PID_IN)) begin
          resp_en  = 1'b1;
          resp_pid = PID_DATA1;
        end else if (tok_ok && (tok_pid == PID_ACK)) begin
          if (pend_is_addr_q) begin
            dev_addr_d = pend_addr_q;
          end else begin
            config_d = pend_cfg_q;
          end
          state_d = ST_IDLE;
        end
      end
      ST_STALLED: begin
        if (tok_ok && ((tok_pid == PID_IN) || (tok_pid == PID_OUT))) begin
          resp_en  = 1'b1;
          resp_pid = PID_STALL;
        end
      end
      default: ;
    endcase

    if (is_setup) begin
      state_d        = ST_SETUP_RX;
      pend_addr_d    = 7'd0;
      pend_cfg_d     = 8'd0;
      pend_is_addr_d = 1'b0;
      out_seen_d     = 1'b0;
      resp_en        = 1'b0;
    end else if (timeout) begin
      state_d        = ST_IDLE;
      pend_addr_d    = 7'd0;
      pend_cfg_d     = 8'd0;
      pend_is_addr_d = 1'b0;
      out_seen_d     = 1'b0;
      resp_en        = 1'b0;
    end

    if (resp_en) begin
      tx_valid_d = 1'b1;
      tx_pid_d   = resp_pid;
      tx_len_d   = resp_len;
      tx_data_d  = resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tx_valid_q     <= 1'b0;
      tx_pid_q       <= 4'd0;
      tx_len_q       <= 16'd0;
      tx_data_q      <= 8'd0;
      dev_addr_q     <= 7'd0;
      config_q       <= 8'd0;
      pend_addr_q    <= 7'd0;
      pend_cfg_q     <= 8'd0;
      pend_is_addr_q <= 1'b0;
      out_seen_q     <= 1'b0;
      out_data_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_valid_q     <= tx_valid_d;
      tx_pid_q       <= tx_pid_d;
      tx_len_q       <= tx_len_d;
      tx_data_q      <= tx_data_d;
      dev_addr_q     <= dev_addr_d;
      config_q       <= config_d;
      pend_addr_q    <= pend_addr_d;
      pend_cfg_q     <= pend_cfg_d;
      pend_is_addr_q <= pend_is_addr_d;
      out_seen_q     <= out_seen_d;
      out_data_q     <= out_data_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_pid     = tx_pid_q;
  assign tx_len     = tx_len_q;
  assign tx_data    = tx_data_q;
  assign dev_addr   = dev_addr_q;
  assign config_val = config_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_usb_ep0_ctrl_seq.sv
// Directed bench for usb_ep0_ctrl_seq; the idle-timeout section is built only with USB_EP0_TIMEOUT_EN.
module tb_usb_ep0_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        tok_valid;
  logic [3:0]  tok_pid;
  logic        rx_data_valid;
  logic [7:0]  rx_data;
  logic        rx_pkt_end;
  logic        rx_crc_err;
  logic        tx_ready;
  logic        tx_valid;
  logic [3:0]  tx_pid;
  logic [15:0] tx_len;
  logic [7:0]  tx_data;
  logic [6:0]  dev_addr;
  logic [7:0]  config_val;
  logic [2:0]  ctrl_state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] P_SETUP = 4'hD, P_IN = 4'h9, P_OUT = 4'h1;
  localparam logic [3:0] P_DATA1 = 4'hB, P_ACK = 4'h2, P_STALL = 4'hE;

  usb_ep0_ctrl_seq #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .tok_valid     (tok_valid),
    .tok_pid       (tok_pid),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .rx_pkt_end    (rx_pkt_end),
    .rx_crc_err    (rx_crc_err),
    .tx_ready      (tx_ready),
    .tx_valid      (tx_valid),
    .tx_pid        (tx_pid),
    .tx_len        (tx_len),
    .tx_data       (tx_data),
    .dev_addr      (dev_addr),
    .config_val    (config_val),
    .ctrl_state    (ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input string tag, input logic [3:0] pid, input logic [15:0] len,
                          input logic [7:0] data);
    check({tag, ".valid"}, 32'(tx_valid), 32'd1);
    check({tag, ".pid"},   32'(tx_pid),   32'(pid));
    check({tag, ".len"},   32'(tx_len),   32'(len));
    check({tag, ".data"},  32'(tx_data),  32'(data));
  endtask

  task automatic send_tok(input logic [3:0] pid);
    tok_valid = 1'b1;
    tok_pid   = pid;
    tick();
    tok_valid = 1'b0;
    tok_pid   = 4'd0;
  endtask

  // Bytes are taken from the top of pkt downwards: pkt[63:56] is byte 0.
  task automatic send_pkt(input logic [63:0] pkt, input int n, input logic crc);
    if (n == 0) begin
      rx_pkt_end = 1'b1;
      rx_crc_err = crc;
      tick();
    end else begin
      for (int i = 0; i < n; i++) begin
        rx_data_valid = 1'b1;
        rx_data       = pkt[63-8*i -: 8];
        rx_pkt_end    = (i == n - 1);
        rx_crc_err    = (i == n - 1) ? crc : 1'b0;
        tick();
      end
    end
    rx_data_valid = 1'b0;
    rx_data       = 8'd0;
    rx_pkt_end    = 1'b0;
    rx_crc_err    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tok_valid = 1'b0; tok_pid = 4'd0; rx_data_valid = 1'b0; rx_data = 8'd0;
    rx_pkt_end = 1'b0; rx_crc_err = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    check("rst.tx_valid", 32'(tx_valid), 32'd0);
    check("rst.tx_pid", 32'(tx_pid), 32'd0);
    check("rst.tx_len", 32'(tx_len), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'd0);
    check("rst.dev_addr", 32'(dev_addr), 32'd0);
    check("rst.config", 32'(config_val), 32'd0);
    check("rst.state", 32'(ctrl_state), 32'd0);
    rst = 1'b0;
    tick();

    // SET_ADDRESS 7 abandoned by a new SETUP before the status ACK.
    send_tok(P_SETUP);
    check("sa7.state_setup", 32'(ctrl_state), 32'd1);
    send_pkt(64'h00_05_07_00_00_00_00_00, 8, 1'b0);
    check_tx("sa7.ack", P_ACK, 16'd0, 8'd0);
    check("sa7.state_stin", 32'(ctrl_state), 32'd4);
    tick();
    send_tok(P_IN);
    check_tx("sa7.zlp", P_DATA1, 16'd0, 8'd0);
    tick();
    send_tok(P_SETUP);
    check("sa7.restart_state", 32'(ctrl_state), 32'd1);
    check("sa7.dev_addr", 32'(dev_addr), 32'd0);

    // SET_ADDRESS 5 through to commit.
    send_pkt(64'h00_05_05_00_00_00_00_00, 8, 1'b0);
    check_tx("sa5.ack", P_ACK, 16'd0, 8'd0);
    tick();
    check("sa5.ack_drop", 32'(tx_valid), 32'd0);
    send_tok(P_IN);
    check_tx("sa5.zlp", P_DATA1, 16'd0, 8'd0);
    check("sa5.addr_before_ack", 32'(dev_addr), 32'd0);
    tick();
    send_tok(P_IN);
    check_tx("sa5.zlp_resend", P_DATA1, 16'd0, 8'd0);
    tick();
    send_tok(P_ACK);
    check("sa5.dev_addr", 32'(dev_addr), 32'd5);
    check("sa5.state_idle", 32'(ctrl_state), 32'd0);

    // SET_CONFIGURATION 1.
    send_tok(P_SETUP);
    send_pkt(64'h00_09_01_00_00_00_00_00, 8, 1'b0);
    check_tx("sc1.ack", P_ACK, 16'd0, 8'd0);
    check("sc1.state", 32'(ctrl_state), 32'd4);
    tick();
    send_tok(P_IN);
    check_tx("sc1.zlp", P_DATA1, 16'd0, 8'd0);
    check("sc1.cfg_before_ack", 32'(config_val), 32'd0);
    tick();
    send_tok(P_ACK);
    check("sc1.config", 32'(config_val), 32'd1);
    check("sc1.dev_addr_kept", 32'(dev_addr), 32'd5);

    // GET_CONFIGURATION with data and OUT status stage.
    send_tok(P_SETUP);
    send_pkt(64'h80_08_00_00_00_00_01_00, 8, 1'b0);
    check_tx("gc.ack", P_ACK, 16'd0, 8'd0);
    check("gc.state_datain", 32'(ctrl_state), 32'd2);
    tick();
    send_tok(P_IN);
    check_tx("gc.data", P_DATA1, 16'd1, 8'h01);
    tick();
    send_tok(P_IN);
    check_tx("gc.data_resend", P_DATA1, 16'd1, 8'h01);
    tick();
    send_tok(P_ACK);
    check("gc.state_stout", 32'(ctrl_state), 32'd3);
    check("gc.no_resp_ack", 32'(tx_valid), 32'd0);
    send_tok(P_OUT);
    check("gc.no_resp_out", 32'(tx_valid), 32'd0);
    send_pkt(64'd0, 0, 1'b0);
    check_tx("gc.status_ack", P_ACK, 16'd0, 8'd0);
    check("gc.state_idle", 32'(ctrl_state), 32'd0);
    tick();

    // Unsupported request (GET_DESCRIPTOR) stalls until the next SETUP.
    send_tok(P_SETUP);
    send_pkt(64'h80_06_00_01_00_00_40_00, 8, 1'b0);
    check_tx("stall.ack", P_ACK, 16'd0, 8'd0);
    check("stall.state", 32'(ctrl_state), 32'd5);
    tick();
    send_tok(P_IN);
    check_tx("stall.in", P_STALL, 16'd0, 8'd0);
    tick();
    send_tok(P_OUT);
    check_tx("stall.out", P_STALL, 16'd0, 8'd0);
    tick();
    send_tok(P_SETUP);
    check("stall.recover", 32'(ctrl_state), 32'd1);

    // Short and corrupt SETUP packets are silently dropped.
    send_pkt(64'h00_05_09_00_00_00_00_00, 7, 1'b0);
    check("short.tx_valid", 32'(tx_valid), 32'd0);
    check("short.state", 32'(ctrl_state), 32'd0);
    send_tok(P_SETUP);
    send_pkt(64'h00_05_09_00_00_00_00_00, 8, 1'b1);
    check("crc.tx_valid", 32'(tx_valid), 32'd0);
    check("crc.state", 32'(ctrl_state), 32'd0);
    send_tok(P_IN);
    check("idle_in.no_resp", 32'(tx_valid), 32'd0);
    check("crc.dev_addr", 32'(dev_addr), 32'd5);

    // Transmitter back-pressure: response held, competing IN dropped.
    send_tok(P_SETUP);
    tx_ready = 1'b0;
    send_pkt(64'h00_05_0A_00_00_00_00_00, 8, 1'b0);
    check_tx("bp.ack", P_ACK, 16'd0, 8'd0);
    send_tok(P_IN);
    check_tx("bp.hold1", P_ACK, 16'd0, 8'd0);
    tick();
    check_tx("bp.hold2", P_ACK, 16'd0, 8'd0);
    tick();
    check_tx("bp.hold3", P_ACK, 16'd0, 8'd0);
    tx_ready = 1'b1;
    check("bp.still_valid", 32'(tx_valid), 32'd1);
    tick();
    check("bp.drop", 32'(tx_valid), 32'd0);
    send_tok(P_IN);
    check_tx("bp.zlp", P_DATA1, 16'd0, 8'd0);
    tick();
    send_tok(P_ACK);
    check("bp.dev_addr", 32'(dev_addr), 32'h0A);

    // Reset mid-transfer loses the pending address.
    send_tok(P_SETUP);
    send_pkt(64'h00_05_03_00_00_00_00_00, 8, 1'b0);
    tick();
    send_tok(P_IN);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.state", 32'(ctrl_state), 32'd0);
    check("mid_rst.tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst.dev_addr", 32'(dev_addr), 32'd0);
    check("mid_rst.config", 32'(config_val), 32'd0);
    send_tok(P_ACK);
    check("mid_rst.no_commit", 32'(dev_addr), 32'd0);

`ifdef USB_EP0_TIMEOUT_EN
    send_tok(P_SETUP);
    send_pkt(64'h00_05_05_00_00_00_00_00, 8, 1'b0);
    check("to.state_stin", 32'(ctrl_state), 32'd4);
    repeat (20) tick();
    check("to.state_idle", 32'(ctrl_state), 32'd0);
    send_tok(P_IN);
    check("to.no_resp", 32'(tx_valid), 32'd0);
    send_tok(P_ACK);
    check("to.dev_addr", 32'(dev_addr), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_ep0_ctrl_seq.md
# usb_ep0_ctrl_seq

Endpoint-0 control-transfer sequencer for the USB device core. Sits between the packet front end and the device state registers. It captures the 8-byte SETUP payload and runs the SETUP/DATA/STATUS stages for the standard device requests SET_ADDRESS, SET_CONFIGURATION and GET_CONFIGURATION. It emits the handshake or data responses and commits the device address only after the status stage completes.

## Interface
- TIMEOUT_CYC, 1024: idle-token cycle limit before abort; used only with USB_EP0_TIMEOUT_EN.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- tok_valid  in  1  one-cycle strobe: token or handshake addressed to this device, EP0.
- tok_pid  in  4  PID qualified by tok_valid (SETUP/IN/OUT/ACK).
- rx_data_valid  in  1  data-packet payload byte strobe.
- rx_data  in  8  payload byte.
- rx_pkt_end  in  1  end of data packet; may coincide with the last rx_data_valid; alone means zero-length packet (ZLP).
- rx_crc_err  in  1  sampled with rx_pkt_end; packet is corrupt.
- tx_ready  in  1  transmitter accepts the response.
- tx_valid  out  1  response pending.
- tx_pid  out  4  response PID (ACK/STALL/DATA1).
- tx_len  out  16  payload length (0 or 1).
- tx_data  out  8  single payload byte.
- dev_addr  out  7  committed device address.
- config_val  out  8  current configuration (0 or 1).
- ctrl_state  out  3  encoded FSM state, debug.

## Operation
- States: IDLE, SETUP_RX, DATA_IN, STATUS_OUT, STATUS_IN, STALLED.
- A SETUP token in any state enters SETUP_RX, clears the byte count and discards any pending address. This includes SETUP during an active transfer.
- SETUP_RX: bytes stored by index 0..7; bytes beyond 8 are ignored.
- At rx_pkt_end, if count≠8 or rx_crc_err: no response, go to IDLE.
- Otherwise send ACK (len 0) and decode.
  - Fields: bmRequestType = byte0, bRequest = byte1, wValue = {b3,b2}, wLength = {b7,b6}.
- Decode:
  - 00/05 (SET_ADDRESS), wValue≤127: latch pending address, go to STATUS_IN.
  - 00/09 (SET_CONFIGURATION), wValue≤1: latch pending configuration, go to STATUS_IN.
  - 80/08 (GET_CONFIGURATION), wLength≥1: go to DATA_IN.
  - Anything else: STALLED.
- DATA_IN:
  - IN token: send DATA1, len 1, data = config_val.
  - ACK token: go to STATUS_OUT.
  - A repeated IN before ACK resends the same packet.
- STATUS_OUT: OUT token followed by a ZLP without CRC error: send ACK, go to IDLE.
- STATUS_IN:
  - IN token: send DATA1, len 0.
  - Host ACK: commit dev_addr or config_val from the pending value, go to IDLE.
  - A repeated IN resends the ZLP.
- STALLED: every IN or OUT token gets STALL. Only SETUP exits.
- IN or OUT tokens in IDLE get no response.
- OUT data in DATA_IN gets no response.
- Tokens arriving while tx_valid is set and tx_ready is low are dropped, except SETUP, which still restarts capture.

## Timing
- Reset values:
  - tx_valid=0, tx_pid=0, tx_len=0, tx_data=0.
  - dev_addr=0, config_val=0.
  - ctrl_state=IDLE, pending values cleared.
- Response latency: tx_valid rises on the clock edge after the triggering tok_valid or rx_pkt_end cycle.
- tx_valid and tx_pid/tx_len/tx_data stay stable until a cycle with tx_ready=1. tx_valid drops on the following edge.
- dev_addr changes on the edge after the status-stage host ACK is sampled, never earlier.
- rst mid-transfer: returns to reset values next edge; pending address is lost.

## Configuration
- USB_EP0_TIMEOUT_EN defined:
  - A 16-bit counter runs in every non-IDLE state and resets on each tok_valid.
  - At TIMEOUT_CYC the FSM goes to IDLE, clears pending values and generates no response.
- Undefined: no counter; the FSM waits indefinitely. TIMEOUT_CYC is ignored.

## Structure
- usb_defs_pkg holds:
  - PID constants: SETUP=D, IN=9, OUT=1, DATA1=B, ACK=2, STALL=E.
  - REQ_SET_ADDRESS=8'h05, REQ_GET_CONFIGURATION=8'h08, REQ_SET_CONFIGURATION=8'h09.
  - ep0_state_t enum.
- Sub-module usb_setup_capture: byte-indexed 8-byte capture, count, CRC/length check, field extraction, one-cycle setup_ok/setup_bad outputs.

## Test plan
- SETUP 00 05 05 00 00 00 00 00, then IN, then ACK -> ACK after SETUP data; DATA1 len 0 after IN; dev_addr 0→5 only after ACK.
- SET_ADDRESS 7, then new SETUP before status ACK -> dev_addr stays 0, FSM goes to SETUP_RX.
- SET_CONFIGURATION 1, then GET_CONFIGURATION (80 08 00 00 00 00 01 00), IN, ACK, OUT, ZLP -> DATA1 len 1 data 01, then ACK; config_val=1.
- SETUP with bRequest 0x06 -> ACK after SETUP data, then STALL on IN and on OUT; next valid SETUP recovers.
- SETUP data with rx_crc_err=1 or 7 bytes -> no tx_valid; ctrl_state returns to IDLE.
- tx_ready held low for 4 cycles -> tx_valid and fields stable, deasserts one edge after tx_ready=1; with USB_EP0_TIMEOUT_EN and TIMEOUT_CYC=16, no token after SET_ADDRESS -> IDLE, dev_addr 0.
